// File: rtl/bls_pkg.sv
// Shared constants and types for the Black-Scholes data server slice.
package bls_pkg;

  localparam int BSMODS   = 2;
  localparam int DATASIZE = 192;
  localparam int ADDR_W   = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN      = 2'd1,
    READ      = 2'd2,
    EXHAUSTED = 2'd3
  } srv_state_t;

  typedef logic [DATASIZE-1:0] bls_record_t;

endpackage

// File: rtl/bls_rr_arbiter.sv
// Round-robin grant over BSMODS requesters; priority starts after the last granted slot.
module bls_rr_arbiter #(
  parameter int  BSMODS = bls_pkg::BSMODS,
  localparam int IDX_W  = (BSMODS > 1) ? $clog2(BSMODS) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BSMODS-1:0] req,
  input  logic              advance,
  output logic [BSMODS-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int unsigned i = 0; i < BSMODS; i++) begin
      logic [IDX_W-1:0] k;
      k = IDX_W'((32'(ptr) + i) % BSMODS);
      if (req[k] && (grant == '0)) begin
        grant[k]  = 1'b1;
        grant_idx = k;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance && (|req)) begin
      ptr <= (grant_idx == IDX_W'(BSMODS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/bls_data_server.sv
// Record server feeding per-BS-module holding registers from a synchronous record memory.
// Optional read-ahead staging register enabled by defining BLS_PREFETCH_EN.
module bls_data_server #(
  parameter int  BSMODS   = bls_pkg::BSMODS,
  parameter int  DATASIZE = bls_pkg::DATASIZE,
  parameter int  ADDR_W   = bls_pkg::ADDR_W,
  localparam int IDX_W    = (BSMODS > 1) ? $clog2(BSMODS) : 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       startSystem,
  input  logic [ADDR_W:0]            num_records,
  input  logic [BSMODS-1:0]          SERVE_REG,
  input  logic [BSMODS-1:0]          BS_START,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATASIZE-1:0]        mem_rdata,
  output logic [BSMODS-1:0]          hasUnusedData,
  output logic [BSMODS-1:0]          REG_READY,
  output logic                       OutOfData,
  output logic [BSMODS*DATASIZE-1:0] bs_data
);

  import bls_pkg::*;

  srv_state_t          state;
  logic [ADDR_W:0]     num_lat;
  logic [ADDR_W:0]     rd_ptr;
  logic [BSMODS-1:0]   has_unused;
  logic [BSMODS-1:0]   reg_ready_q;
  logic                out_of_data;
  logic [DATASIZE-1:0] slot_q [BSMODS];
  logic [BSMODS-1:0]   eligible;
  logic [BSMODS-1:0]   grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                advance;

  assign eligible = SERVE_REG & ~has_unused;

`ifdef BLS_PREFETCH_EN
  logic                stg_valid;
  logic                rd_pend;
  bls_record_t         stg_data;
  logic                prefetch;

  // A grant only needs a staged record; memory reads run independently of requests.
  assign advance   = (state == SCAN) && stg_valid && (|eligible);
  assign prefetch  = (state == SCAN) && !stg_valid && !rd_pend && (rd_ptr != num_lat);
  assign mem_rd_en = prefetch;
  assign mem_addr  = prefetch ? rd_ptr[ADDR_W-1:0] : '0;
  assign REG_READY = reg_ready_q & ~(advance ? grant : '0);
`else
  logic [IDX_W-1:0]    cap_idx;

  assign advance   = (state == SCAN) && (rd_ptr != num_lat) && (|eligible);
  assign mem_rd_en = advance;
  assign mem_addr  = advance ? rd_ptr[ADDR_W-1:0] : '0;
  assign REG_READY = reg_ready_q;
`endif

  bls_rr_arbiter #(.BSMODS(BSMODS)) u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (eligible),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      num_lat     <= '0;
      rd_ptr      <= '0;
      has_unused  <= '0;
      reg_ready_q <= '0;
      out_of_data <= 1'b0;
      slot_q      <= '{default: '0};
`ifdef BLS_PREFETCH_EN
      stg_valid   <= 1'b0;
      rd_pend     <= 1'b0;
      stg_data    <= '0;
`else
      cap_idx     <= '0;
`endif
    end else begin
      // Consumption first; a same-cycle load into a slot overrides below.
      has_unused <= has_unused & ~BS_START;
      case (state)
        IDLE: begin
          if (startSystem) begin
            num_lat <= num_records;
            rd_ptr  <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
`ifdef BLS_PREFETCH_EN
          if (rd_pend) begin
            stg_data  <= mem_rdata;
            stg_valid <= 1'b1;
            rd_ptr    <= rd_ptr + 1'b1;
            rd_pend   <= 1'b0;
          end
          if (prefetch) begin
            rd_pend <= 1'b1;
          end
          if (advance) begin
            slot_q[grant_idx]      <= stg_data;
            has_unused[grant_idx]  <= 1'b1;
            reg_ready_q[grant_idx] <= 1'b1;
            stg_valid              <= 1'b0;
          end else if ((rd_ptr == num_lat) && !stg_valid && !rd_pend) begin
            out_of_data <= 1'b1;
            state       <= EXHAUSTED;
          end
`else
          if (rd_ptr == num_lat) begin
            out_of_data <= 1'b1;
            state       <= EXHAUSTED;
          end else if (advance) begin
            cap_idx                <= grant_idx;
            reg_ready_q[grant_idx] <= 1'b0;
            state                  <= READ;
          end
`endif
        end
        READ: begin
`ifdef BLS_PREFETCH_EN
          state <= SCAN;
`else
          slot_q[cap_idx]      <= mem_rdata;
          has_unused[cap_idx]  <= 1'b1;
          reg_ready_q[cap_idx] <= 1'b1;
          rd_ptr               <= rd_ptr + 1'b1;
          state                <= SCAN;
`endif
        end
        EXHAUSTED: begin
          if (startSystem) begin
            out_of_data <= 1'b0;
            num_lat     <= num_records;
            rd_ptr      <= '0;
            state       <= SCAN;
`ifdef BLS_PREFETCH_EN
            stg_valid   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hasUnusedData = has_unused;
  assign OutOfData     = out_of_data;

  for (genvar g = 0; g < BSMODS; g++) begin : g_slot
    assign bs_data[g*DATASIZE +: DATASIZE] = slot_q[g];
  end

endmodule

// File: tb/tb_bls_data_server.sv
// Directed bench for bls_data_server; a prefetch-only sequence runs when BLS_PREFETCH_EN is defined.
module tb_bls_data_server;

  localparam int DS = 192;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          startSystem = 1'b0;
  logic [10:0]   num_records = '0;
  logic [1:0]    SERVE_REG = '0;
  logic [1:0]    BS_START = '0;
  logic          mem_rd_en;
  logic [9:0]    mem_addr;
  logic [DS-1:0] mem_rdata = '0;
  logic [1:0]    hasUnusedData;
  logic [1:0]    REG_READY;
  logic          OutOfData;
  logic [2*DS-1:0] bs_data;

  int checks = 0;
  int errors = 0;
  int addr_q[$];

  typedef struct {
    logic        start;
    logic [10:0] num;
    logic [1:0]  serve;
    logic [1:0]  bst;
    logic        rd_en;
    logic [9:0]  addr;
    logic [1:0]  hu;
    logic [1:0]  rr;
    logic        ood;
  } vec_t;
  vec_t vq[$];

  bls_data_server dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .startSystem   (startSystem),
    .num_records   (num_records),
    .SERVE_REG     (SERVE_REG),
    .BS_START      (BS_START),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .hasUnusedData (hasUnusedData),
    .REG_READY     (REG_READY),
    .OutOfData     (OutOfData),
    .bs_data       (bs_data)
  );

  always #5 clock = ~clock;

  function automatic logic [DS-1:0] rec(input int a);
    logic [63:0] x;
    x = 64'(a);
    return {64'hA11C_E000_0000_0000 ^ x, 64'h0B0B_0000_0000_1000 + x, ~x};
  endfunction

  always @(posedge clock) begin
    if (mem_rd_en) mem_rdata <= rec(int'(mem_addr));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rec(input string nm, input logic [DS-1:0] act, input logic [DS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    startSystem = 1'b0;
    num_records = '0;
    SERVE_REG   = '0;
    BS_START    = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({nm, "_addr"},  32'(mem_addr), 0);
    chk({nm, "_hu"},    32'(hasUnusedData), 0);
    chk({nm, "_rr"},    32'(REG_READY), 0);
    chk({nm, "_ood"},   32'(OutOfData), 0);
    chk({nm, "_data_nz"}, 32'(|bs_data), 0);
  endtask

  // Runs until every bit in mask of hasUnusedData is set, logging read addresses.
  task automatic run_until(input string nm, input logic [1:0] mask, input int maxc);
    for (int c = 0; c < maxc; c++) begin
      @(negedge clock);
      if (mem_rd_en) addr_q.push_back(int'(mem_addr));
      step();
      if ((hasUnusedData & mask) == mask) break;
    end
    chk(nm, 32'(hasUnusedData & mask), 32'(mask));
  endtask

  task automatic addv(input logic s, input int n, input logic [1:0] sv, input logic [1:0] b,
                      input logic re, input int ad, input logic [1:0] h, input logic [1:0] r,
                      input logic o);
    vec_t v;
    v.start = s; v.num = 11'(n); v.serve = sv; v.bst = b;
    v.rd_en = re; v.addr = 10'(ad); v.hu = h; v.rr = r; v.ood = o;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clock);
    chk_zero("reset");
    step();

`ifdef BLS_PREFETCH_EN
    // Prefetch: staging fills from address 0 before any request.
    startSystem = 1'b1; num_records = 11'd2;
    step();
    startSystem = 1'b0;
    @(negedge clock);
    chk("t6_rd_en", 32'(mem_rd_en), 1);
    chk("t6_addr", 32'(mem_addr), 0);
    step();
    step();
    @(negedge clock);
    chk("t6_full_rd_en", 32'(mem_rd_en), 0);
    chk("t6_full_hu", 32'(hasUnusedData), 0);
    SERVE_REG = 2'b01;
    step();
    SERVE_REG = 2'b00;
    @(negedge clock);
    chk("t6_hu_t1", 32'(hasUnusedData), 32'h1);
    chk_rec("t6_slot0", bs_data[0 +: DS], rec(0));
    for (int c = 0; c < 6; c++) step();
    @(negedge clock);
    chk("t6_ood_staged", 32'(OutOfData), 0);
    SERVE_REG = 2'b10;
    step();
    SERVE_REG = 2'b00;
    chk("t6_hu_both", 32'(hasUnusedData), 32'h3);
    chk_rec("t6_slot1", bs_data[DS +: DS], rec(1));
    for (int c = 0; c < 5 && !OutOfData; c++) step();
    chk("t6_ood", 32'(OutOfData), 1);
`else
    // Table: three records, both slots requesting, one consume, then ignored inputs.
    addv(1, 3, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    addv(0, 3, 2'b11, 2'b00, 1, 0, 2'b00, 2'b00, 0);
    addv(0, 3, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    addv(0, 3, 2'b11, 2'b00, 1, 1, 2'b01, 2'b01, 0);
    addv(0, 3, 2'b11, 2'b00, 0, 0, 2'b01, 2'b01, 0);
    addv(0, 3, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 0);
    addv(0, 3, 2'b11, 2'b01, 0, 0, 2'b11, 2'b11, 0);
    addv(0, 3, 2'b11, 2'b00, 1, 2, 2'b10, 2'b11, 0);
    addv(0, 3, 2'b11, 2'b00, 0, 0, 2'b10, 2'b10, 0);
    addv(0, 3, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 0);
    addv(0, 3, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 1);
    addv(0, 3, 2'b00, 2'b10, 0, 0, 2'b11, 2'b11, 1);
    addv(1, 2, 2'b00, 2'b00, 0, 0, 2'b01, 2'b11, 1);
    addv(0, 2, 2'b01, 2'b10, 0, 0, 2'b01, 2'b11, 0);
    addv(0, 2, 2'b01, 2'b10, 0, 0, 2'b01, 2'b11, 0);
    addv(0, 2, 2'b00, 2'b00, 0, 0, 2'b01, 2'b11, 0);
    for (int i = 0; i < vq.size(); i++) begin
      startSystem = vq[i].start;
      num_records = vq[i].num;
      SERVE_REG   = vq[i].serve;
      BS_START    = vq[i].bst;
      @(negedge clock);
      chk($sformatf("v%0d_rd_en", i), 32'(mem_rd_en), 32'(vq[i].rd_en));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vq[i].addr));
      chk($sformatf("v%0d_hu", i), 32'(hasUnusedData), 32'(vq[i].hu));
      chk($sformatf("v%0d_rr", i), 32'(REG_READY), 32'(vq[i].rr));
      chk($sformatf("v%0d_ood", i), 32'(OutOfData), 32'(vq[i].ood));
      step();
    end
    chk_rec("t1_slot0", bs_data[0 +: DS], rec(2));
    chk_rec("t1_slot1", bs_data[DS +: DS], rec(1));

    // Zero records: exhausted two cycles after start, no reads.
    do_reset();
    begin
      int rdcnt = 0;
      num_records = 11'd0; startSystem = 1'b1;
      step();
      startSystem = 1'b0; SERVE_REG = 2'b11;
      @(negedge clock);
      if (mem_rd_en) rdcnt++;
      chk("t2_ood_early", 32'(OutOfData), 0);
      step();
      @(negedge clock);
      chk("t2_ood", 32'(OutOfData), 1);
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        if (mem_rd_en) rdcnt++;
        step();
      end
      chk("t2_rdcnt", 32'(rdcnt), 0);
      chk("t2_hu", 32'(hasUnusedData), 0);
    end

    // Continuous requests with immediate consumption: strict alternation.
    do_reset();
    begin
      int rises = 0;
      logic [1:0] prev = '0;
      addr_q.delete();
      num_records = 11'd6; startSystem = 1'b1;
      step();
      startSystem = 1'b0; SERVE_REG = 2'b11;
      for (int c = 0; c < 80 && rises < 6; c++) begin
        BS_START = hasUnusedData & ~prev;
        for (int s = 0; s < 2; s++) begin
          if (BS_START[s]) begin
            chk($sformatf("t3_slot_%0d", rises), 32'(s), 32'(rises % 2));
            chk_rec($sformatf("t3_data_%0d", rises), bs_data[DS*s +: DS], rec(rises));
            rises++;
          end
        end
        prev = hasUnusedData;
        @(negedge clock);
        if (mem_rd_en) addr_q.push_back(int'(mem_addr));
        step();
      end
      BS_START = '0;
      chk("t3_count", 32'(rises), 6);
      chk("t3_nreads", 32'(addr_q.size()), 6);
      for (int k = 0; k < addr_q.size(); k++)
        chk($sformatf("t3_addr_%0d", k), 32'(addr_q[k]), 32'(k));
      for (int c = 0; c < 5 && !OutOfData; c++) step();
      chk("t3_ood", 32'(OutOfData), 1);
    end

    // Reset during READ, then restart: pre-reset result must not land anywhere.
    do_reset();
    num_records = 11'd2; startSystem = 1'b1; SERVE_REG = 2'b01;
    step();
    startSystem = 1'b0;
    @(negedge clock);
    chk("t5_pre_rd", 32'(mem_rd_en), 1);
    step();
    reset_n = 1'b0;
    #1;
    chk_zero("t5_rst");
    @(posedge clock);
    @(negedge clock);
    chk_zero("t5_rst_hold");
    reset_n = 1'b1;
    SERVE_REG = 2'b00;
    step();
    addr_q.delete();
    num_records = 11'd2; startSystem = 1'b1; SERVE_REG = 2'b10;
    step();
    startSystem = 1'b0;
    run_until("t5_wait1", 2'b10, 10);
    SERVE_REG = 2'b01;
    run_until("t5_wait0", 2'b01, 10);
    SERVE_REG = 2'b00;
    chk("t5_nreads", 32'(addr_q.size()), 2);
    if (addr_q.size() == 2) begin
      chk("t5_addr0", 32'(addr_q[0]), 0);
      chk("t5_addr1", 32'(addr_q[1]), 1);
    end
    chk_rec("t5_slot1", bs_data[DS +: DS], rec(0));
    chk_rec("t5_slot0", bs_data[0 +: DS], rec(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bls_data_server.md
Name: bls_data_server

Overview:
- Responder end of the SERVE_REG / REG_READY / hasUnusedData / OutOfData handshake driven by the Black-Scholes dispatch controller.
- Reads option-parameter records (DATASIZE bits each) from a synchronous record memory.
- Loads each record into a per-module holding register for a BS module, and reports when the record stream is exhausted.

Parameters:
- BSMODS, 2, number of BS modules / holding-register slots.
- DATASIZE, 192, bits per option record.
- ADDR_W, 10, record memory address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- startSystem  in  1  pulse; latches num_records and starts serving.
- num_records  in  ADDR_W+1  record count; sampled only on startSystem.
- SERVE_REG  in  BSMODS  per-slot fetch request from the dispatch controller.
- BS_START  in  BSMODS  per-slot start pulse; the slot's record is consumed.
- mem_rd_en  out  1  record memory read enable.
- mem_addr  out  ADDR_W  record memory address.
- mem_rdata  in  DATASIZE  read data, valid exactly 1 cycle after mem_rd_en.
- hasUnusedData  out  BSMODS  slot holds a record not yet started.
- REG_READY  out  BSMODS  slot register stable and valid to sample.
- OutOfData  out  1  every record has been fetched.
- bs_data  out  BSMODS*DATASIZE  slot i occupies bits [i*DATASIZE +: DATASIZE].

Behaviour:
- Reset (async, reset_n=0): all outputs 0, including bs_data; state IDLE, rd_ptr=0, round-robin pointer=0.
- FSM states: IDLE, SCAN, READ, EXHAUSTED.
  - IDLE: on startSystem, latch num_records, rd_ptr=0, go to SCAN.
  - SCAN:
    - If rd_ptr==num_lat: go to EXHAUSTED; OutOfData=1 from the next cycle.
    - Else, eligible slots are SERVE_REG[i] & ~hasUnusedData[i]. If any are eligible, grant one round-robin, starting the search after the last granted slot.
    - On grant: mem_rd_en=1, mem_addr=rd_ptr[ADDR_W-1:0], go to READ.
  - READ: capture mem_rdata into slot g; hasUnusedData[g]<=1; rd_ptr<=rd_ptr+1; go to SCAN. REG_READY[g] is 0 during this capture cycle and 1 afterwards.
  - EXHAUSTED: OutOfData held at 1. startSystem restarts: OutOfData<=0, re-latch num_records, rd_ptr=0, go to SCAN.
- Only one memory read is outstanding at a time.
- Latency: SERVE_REG seen in SCAN at cycle t gives hasUnusedData=1 at t+2. The next grant is possible at t+2.
- Consumption: BS_START[i] with hasUnusedData[i]=1 clears hasUnusedData[i] next cycle. bs_data slot i holds its value until the slot is reloaded.
- Ignored inputs, each with no effect:
  - BS_START[i] with hasUnusedData[i]=0.
  - SERVE_REG[i] with hasUnusedData[i]=1.
  - SERVE_REG while IDLE or EXHAUSTED.
- A slot in capture never has hasUnusedData=1, so a BS_START/capture collision on the same slot cannot occur.
- Boundaries:
  - num_records=0 → EXHAUSTED with no reads.
  - rd_ptr is ADDR_W+1 bits, so a full 2^ADDR_W records are readable.
  - startSystem outside IDLE/EXHAUSTED is ignored.
- Reset mid-READ: the pending capture is discarded and the memory result is ignored.

Optional Feature:
- Macro: BLS_PREFETCH_EN.
- Defined:
  - Adds a one-record staging register with a valid bit.
  - The server reads ahead whenever staging is empty and rd_ptr<num_lat.
  - A grant moves staging into slot g in one cycle: SERVE_REG at t gives hasUnusedData at t+1.
  - OutOfData=1 only when rd_ptr==num_lat and staging is empty.
  - Reset and restart clear staging valid.
- Undefined: fetch-on-demand exactly as described above, with no staging logic.

Decomposition:
- Package bls_pkg holds:
  - BSMODS, DATASIZE, ADDR_W constants.
  - state enum srv_state_t.
  - typedef bls_record_t logic[DATASIZE-1:0].
- One sub-module: bls_rr_arbiter, a BSMODS-wide round-robin grant.
  - Inputs: req, advance. Outputs: grant one-hot, grant index.

Test Plan:
1. num_records=3, records A,B,C; SERVE_REG=2'b11 held; no BS_START.
   - slot0=A, then slot1=B.
   - hasUnusedData=2'b11; mem_rd_en is not asserted again.
   - A BS_START[0] pulse then loads slot0=C, followed by OutOfData=1.
2. num_records=0; startSystem pulse.
   - OutOfData=1 two cycles later; mem_rd_en never asserted; hasUnusedData=0.
3. Both slots request continuously, each consumed via BS_START on the cycle its hasUnusedData rises; 6 records.
   - Grant order is 0,1,0,1,0,1.
   - Addresses are 0..5 in order.
4. BS_START[1] while hasUnusedData[1]=0; SERVE_REG[0] while hasUnusedData[0]=1.
   - No state change; no memory read.
5. reset_n low during READ, then startSystem with num_records=2.
   - All outputs are 0 during reset.
   - Restart fetches addresses 0 and 1, with the captured data equal to the records stored at addresses 0 and 1; the pre-reset read result is not used.
6. BLS_PREFETCH_EN defined, num_records=2.
   - After startSystem, staging fills with address 0.
   - SERVE_REG[0] at t gives hasUnusedData[0]=1 at t+1.
   - OutOfData=1 only after both records reach slots.
